// File: rtl/matrix_frame_loader.sv
// matrix_frame_loader: reads a parsed frame out of the number RAM (rows, cols,
// then elements), validates dimensions against the value count and streams the
// elements row-major over a valid/ready interface.
module matrix_frame_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned MAX_DIM    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [10:0]           num_count,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [7:0]            rows,
  output logic [7:0]            cols,
  output logic [DATA_WIDTH-1:0] elem_data,
  output logic [7:0]            elem_row,
  output logic [7:0]            elem_col,
  output logic                  elem_valid,
  output logic                  elem_last,
  input  logic                  elem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_ROWS,
    S_RD_COLS,
    S_CHECK,
    S_FETCH,
    S_CAPTURE,
    S_PRESENT,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_SHORT    = 2'd1;
  localparam logic [1:0] ERR_BAD_DIM  = 2'd2;
  localparam logic [1:0] ERR_MISMATCH = 2'd3;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]            rows_q, rows_d;
  logic [7:0]            cols_q, cols_d;
  logic                  rows_bad_q, rows_bad_d;
  logic [7:0]            row_q, row_d;
  logic [7:0]            col_q, col_d;
  logic [DATA_WIDTH-1:0] elem_data_q, elem_data_d;
  logic [7:0]            elem_row_q, elem_row_d;
  logic [7:0]            elem_col_q, elem_col_d;
  logic                  elem_valid_q, elem_valid_d;
  logic                  elem_last_q, elem_last_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [15:0]           expected_count;

  // A dimension is legal only as a strictly positive value no larger than MAX_DIM.
  function automatic logic dim_bad(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] || (v == '0) || (v > DATA_WIDTH'(MAX_DIM));
  endfunction

  // Rows only survives as 8 bits, so its full-width legality is judged when it
  // is read and carried into CHECK as a flag.
  assign expected_count = 16'd2 + (16'(rows_q) * 16'(rd_data[7:0]));

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rd_addr_q    <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      rows_bad_q   <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      elem_data_q  <= '0;
      elem_row_q   <= '0;
      elem_col_q   <= '0;
      elem_valid_q <= 1'b0;
      elem_last_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      rows_bad_q   <= rows_bad_d;
      row_q        <= row_d;
      col_q        <= col_d;
      elem_data_q  <= elem_data_d;
      elem_row_q   <= elem_row_d;
      elem_col_q   <= elem_col_d;
      elem_valid_q <= elem_valid_d;
      elem_last_q  <= elem_last_d;
      err_code_q   <= err_code_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    rows_bad_d   = rows_bad_q;
    row_d        = row_q;
    col_d        = col_q;
    elem_data_d  = elem_data_q;
    elem_row_d   = elem_row_q;
    elem_col_d   = elem_col_q;
    elem_valid_d = elem_valid_q;
    elem_last_d  = elem_last_q;
    err_code_d   = err_code_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          if (num_count < 11'd2) begin
            state_d    = S_ERROR;
            err_code_d = ERR_SHORT;
          end else begin
            state_d    = S_RD_ROWS;
            rd_addr_d  = '0;
            err_code_d = ERR_NONE;
          end
        end
      end
      S_RD_ROWS: begin
        rd_addr_d = ADDR_WIDTH'(1);
        state_d   = S_RD_COLS;
      end
      S_RD_COLS: begin
        rows_d     = rd_data[7:0];
        rows_bad_d = dim_bad(rd_data);
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        cols_d = rd_data[7:0];
        if (rows_bad_q || dim_bad(rd_data)) begin
          state_d    = S_ERROR;
          err_code_d = ERR_BAD_DIM;
        end else if (16'(num_count) != expected_count) begin
          state_d    = S_ERROR;
          err_code_d = ERR_MISMATCH;
        end else begin
          rd_addr_d = ADDR_WIDTH'(2);
          row_d     = '0;
          col_d     = '0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        elem_data_d  = rd_data;
        elem_row_d   = row_q;
        elem_col_d   = col_q;
        elem_valid_d = 1'b1;
        elem_last_d  = (row_q == rows_q - 8'd1) && (col_q == cols_q - 8'd1);
        state_d      = S_PRESENT;
      end
      S_PRESENT: begin
        if (elem_ready) begin
          elem_valid_d = 1'b0;
          if (elem_last_q) begin
            state_d = S_DONE;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            if (col_q == cols_q - 8'd1) begin
              col_d = '0;
              row_d = row_q + 8'd1;
            end else begin
              col_d = col_q + 8'd1;
            end
            state_d = S_FETCH;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rd_addr    = rd_addr_q;
  assign rows       = rows_q;
  assign cols       = cols_q;
  assign elem_data  = elem_data_q;
  assign elem_row   = elem_row_q;
  assign elem_col   = elem_col_q;
  assign elem_valid = elem_valid_q;
  assign elem_last  = elem_last_q;
  assign err_code   = err_code_q;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);

endmodule

// File: tb/tb_matrix_frame_loader.sv
// tb_matrix_frame_loader: random and directed frames against a frame-level
// reference model (expected element list, error code and completion cycle).
module tb_matrix_frame_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] num_count;
  logic [10:0] rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  rows, cols;
  logic [31:0] elem_data;
  logic [7:0]  elem_row, elem_col;
  logic        elem_valid, elem_last, elem_ready;
  logic        busy, done, error;
  logic [1:0]  err_code;

  matrix_frame_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .MAX_DIM(32)) dut (
    .clk(clk), .rst(rst), .start(start), .num_count(num_count),
    .rd_addr(rd_addr), .rd_data(rd_data), .rows(rows), .cols(cols),
    .elem_data(elem_data), .elem_row(elem_row), .elem_col(elem_col),
    .elem_valid(elem_valid), .elem_last(elem_last), .elem_ready(elem_ready),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Number RAM with one-cycle read latency.
  logic [31:0] mem [0:2047];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    int          r;
    int          c;
    bit          l;
  } elem_t;

  int    frame_q[$];
  elem_t exp_q[$];
  logic [7:0] prev_rows = 8'd0;
  logic [7:0] prev_cols = 8'd0;

  // ready_mode: 0 always ready, 1 random, 2 repeating 1-0-0-1.
  task automatic run_frame(input int unsigned ncount, input int unsigned ready_mode, input bit poke);
    int exp_err, exp_cyc, r, c, n, cyc, stalls, pidx;
    bit finished, stalled, rdy, saw_valid;
    logic [63:0] snap, cur;
    elem_t e;

    for (int i = 0; i < frame_q.size(); i++) mem[i] = frame_q[i];
    exp_q.delete();
    if (ncount < 2) begin
      exp_err = 1;
      exp_cyc = 1;
    end else begin
      r = frame_q[0];
      c = frame_q[1];
      prev_rows = 8'(r);
      prev_cols = 8'(c);
      exp_cyc = 4;
      if (r < 1 || r > 32 || c < 1 || c > 32) exp_err = 2;
      else if (ncount != 2 + r * c) exp_err = 3;
      else begin
        exp_err = 0;
        n = r * c;
        for (int k = 0; k < n; k++) begin
          e.d = frame_q[2 + k];
          e.r = k / c;
          e.c = k % c;
          e.l = (k == n - 1);
          exp_q.push_back(e);
        end
        exp_cyc = 3 * n + 4;
      end
    end

    num_count = 11'(ncount);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; stalls = 0; pidx = 0; stalled = 0; finished = 0; saw_valid = 0; snap = '0;
    while (!finished && cyc < 400) begin
      if (done || error) begin
        finished = 1;
      end else begin
        if (poke) start = (cyc == 5);
        cur = {14'd0, elem_valid, elem_last, elem_row, elem_col, elem_data};
        if (stalled) check_val("stall_hold", cur, snap);
        if (elem_valid) begin
          saw_valid = 1;
          case (ready_mode)
            0:       rdy = 1;
            1:       rdy = ($urandom_range(0, 2) != 0);
            default: rdy = (pidx % 4 == 0) || (pidx % 4 == 3);
          endcase
          pidx++;
          elem_ready = rdy;
          if (rdy) begin
            if (exp_q.size() == 0) begin
              check_val("extra_elem", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check_val("elem_data", elem_data, e.d);
              check_val("elem_row", elem_row, 8'(e.r));
              check_val("elem_col", elem_col, 8'(e.c));
              check_val("elem_last", elem_last, e.l);
            end
          end else begin
            stalls++;
          end
          stalled = !rdy;
          snap = cur;
        end else begin
          elem_ready = 1'($urandom_range(0, 1));
          stalled = 0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    elem_ready = 1'b0;
    if (!finished) check_val("timeout", 1, 0);
    check_val("err_code", err_code, exp_err);
    check_val("done", done, exp_err == 0);
    check_val("error", error, exp_err != 0);
    check_val("busy_end", busy, 0);
    check_val("end_cycle", cyc, exp_cyc + stalls);
    check_val("rows", rows, prev_rows);
    check_val("cols", cols, prev_cols);
    check_val("elems_left", exp_q.size(), 0);
    if (exp_err != 0) check_val("valid_on_err", saw_valid, 0);
  endtask

  task automatic set_frame_2x3();
    frame_q = '{2, 3, 1, -2, 3, 4, 5, 6};
  endtask

  initial begin
    int r, c, kind, cnt, bad;
    int bad_vals[5];
    bad_vals = '{0, 33, -1, 258, -5};
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    rst = 1'b1; start = 1'b0; num_count = '0; elem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_a", {rd_addr, rows, cols, elem_row, elem_col}, '0);
    check_val("reset_b", {elem_data, elem_valid, elem_last, busy, done, error, err_code}, '0);
    rst = 1'b0;

    set_frame_2x3();                 run_frame(8, 0, 0);
    set_frame_2x3();                 run_frame(8, 2, 0);
    frame_q = '{2, 2, 1, 2, 3};      run_frame(5, 0, 0);
    frame_q = '{33, 1, 9, 9};        run_frame(8, 0, 0);
    frame_q = '{-1, 4, 9, 9};        run_frame(6, 0, 0);
    frame_q = '{};                   run_frame(1, 0, 0);

    // Reset while an element is stalled in PRESENT.
    set_frame_2x3();
    for (int i = 0; i < frame_q.size(); i++) mem[i] = frame_q[i];
    num_count = 11'd8;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    elem_ready = 1'b0;
    cnt = 0;
    while (!elem_valid && cnt < 50) begin @(negedge clk); cnt++; end
    check_val("reached_present", elem_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_mid_a", {rd_addr, rows, cols, elem_row, elem_col}, '0);
    check_val("rst_mid_b", {elem_data, elem_valid, elem_last, busy, done, error, err_code}, '0);
    rst = 1'b0;
    prev_rows = 8'd0; prev_cols = 8'd0;
    run_frame(8, 1, 0);

    frame_q = '{1, 1, 7};            run_frame(3, 0, 1);

    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 3);
      r = $urandom_range(1, 5);
      c = $urandom_range(1, 5);
      frame_q = '{r, c};
      for (int k = 0; k < r * c; k++) frame_q.push_back(int'($urandom));
      case (kind)
        0: run_frame(2 + r * c, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        1: run_frame(($urandom_range(0, 1) != 0) ? 3 + r * c : 1 + r * c, 0, 0);
        2: begin
          bad = bad_vals[$urandom_range(0, 4)];
          if ($urandom_range(0, 1) != 0) frame_q[0] = bad; else frame_q[1] = bad;
          run_frame(2 + r * c, 0, 0);
        end
        default: run_frame($urandom_range(0, 1), 0, 0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/matrix_frame_loader.md
# matrix_frame_loader

Downstream consumer of the ASCII number separator. Once separation finishes, it reads the parsed int32 values out of the separator's number RAM. Values 0 and 1 are taken as row and column counts. The block checks that the dimensions and the number count agree, then streams the matrix elements in row-major order over a valid/ready interface toward matrix storage. Malformed frames are rejected with an error code and no elements are emitted.

## Interface
- `DATA_WIDTH`, 32, width of an RAM word and of an element.
- `ADDR_WIDTH`, 11, number RAM address width.
- `MAX_DIM`, 32, largest legal row or column count (must be ≤255).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a load (driven by separator `done` rising edge).
- `num_count`  in  11  number of values held in the number RAM.
- `rd_addr`  out  ADDR_WIDTH  number RAM read address (registered).
- `rd_data`  in  DATA_WIDTH  number RAM read data, signed. Data in cycle N+1 belongs to `rd_addr` of cycle N.
- `rows`, `cols`  out  8  captured dimensions; valid while `done`.
- `elem_data`  out  DATA_WIDTH  element value.
- `elem_row`, `elem_col`  out  8  element coordinates.
- `elem_valid`  out  1  element present.
- `elem_last`  out  1  final element; qualified by `elem_valid`.
- `elem_ready`  in  1  consumer accepts.
- `busy`  out  1  high in any state other than IDLE/DONE/ERROR.
- `done`  out  1  level; high in DONE.
- `error`  out  1  level; high in ERROR.
- `err_code`  out  2  0 none, 1 SHORT, 2 BAD_DIM, 3 COUNT_MISMATCH.

## Operation
States: IDLE, RD_ROWS, RD_COLS, CHECK, FETCH, CAPTURE, PRESENT, DONE, ERROR.

- **IDLE/DONE/ERROR + `start`:**
  - If `num_count` < 2: go to ERROR with `err_code`=1.
  - Otherwise: set `rd_addr`←0 and go to RD_ROWS. Clear `done`, `error` and `err_code`.
- **RD_ROWS:** set `rd_addr`←1 and go to RD_COLS.
- **RD_COLS:** `rd_data` holds value 0; latch it as rows. Go to CHECK.
- **CHECK:** `rd_data` holds value 1; latch it as cols. The check uses the full signed 32-bit values.
  - rows ≤0, rows >MAX_DIM, cols ≤0 or cols >MAX_DIM: go to ERROR with `err_code`=2.
  - Otherwise, `num_count` ≠ 2+rows·cols (product computed at 16 bits): go to ERROR with `err_code`=3.
  - Otherwise: set `rd_addr`←2, row=col=0, and go to FETCH.
- **FETCH:** address stable; go to CAPTURE.
- **CAPTURE:** `elem_data`←`rd_data`, `elem_valid`←1, `elem_last`←(row==rows-1 && col==cols-1). Go to PRESENT.
- **PRESENT:** hold all `elem_*` outputs stable until `elem_valid && elem_ready`. On the handshake:
  - `elem_valid`←0.
  - If last: go to DONE.
  - Otherwise: `rd_addr`+1; col+1, wrapping to 0 with row+1 at cols-1; go to FETCH.
- `start` in any busy state is ignored.
- ERROR and DONE hold until the next `start` or `rst`.
- `rows`/`cols` keep their last latched values after ERROR.

## Timing
- Reset values: state IDLE. `rd_addr`, `rows`, `cols`, `elem_data`, `elem_row`, `elem_col` = 0. `elem_valid`, `elem_last`, `busy`, `done`, `error` = 0. `err_code` = 0.
- Reset takes effect on the next edge from any state; `elem_valid` drops immediately with it. `rst` wins over a simultaneous `start`.
- SHORT error: `error` is high one cycle after the `start` cycle.
- Dimension/count errors: `start` at cycle 0; RD_ROWS cycle 1, RD_COLS cycle 2, CHECK cycle 3; ERROR is visible at cycle 4.
- First element: FETCH at cycle 4, CAPTURE at cycle 5; `elem_valid` is high from cycle 6.
- Throughput: one element per 3 cycles with `elem_ready` held high. Each stall cycle in PRESENT adds one cycle.
- `done` rises the cycle after the last handshake. `busy` falls in the same cycle.
- `elem_ready` is sampled only in PRESENT. Ready without valid has no effect.

## Test plan
- 2×3 frame, RAM = [2,3,1,-2,3,4,5,6], `num_count`=8, ready tied high -> six elements 1,-2,3,4,5,6 with coords (0,0)…(1,2). `elem_last` on the 6th only. `done` at cycle 22 after `start`, `err_code`=0.
- Same frame with ready toggled 1-0-0-1 -> element order and values unchanged, `elem_*` stable while stalled, no duplicates or drops.
- RAM = [2,2,1,2,3], `num_count`=5 -> ERROR with `err_code`=3 at cycle 4. `elem_valid` never asserts.
- RAM = [33,1,…] and RAM = [-1,4,…] -> `err_code`=2 in both cases. `num_count`=1 -> `err_code`=1 one cycle after `start`.
- `rst` asserted while PRESENT is stalled -> all outputs return to reset values on the next edge. A fresh `start` then reloads the frame correctly.
- From DONE, `start` with a new 1×1 frame [1,1,7] -> one element 7 with `elem_last`=1. A `start` pulse during busy is ignored.
